// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Five-stage pipeline hazard/stall controller with a multi-cycle
//            multiply/divide sequencer. Produces per-stage stall and refresh
//            (bubble) controls combinationally from the current hazards.
// Options  : MD_MULT_MC_EN - when defined, ex_mult also runs through the
//            multi-cycle sequencer with latency MUL_LAT; otherwise ex_mult
//            is treated as single-cycle and ignored here.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int DIV_LAT = 32,
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  // ID stage source operands
  input  logic       id_rs_ren,
  input  logic       id_rt_ren,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  // EX stage instruction attributes
  input  logic       ex_regwen,
  input  logic [4:0] ex_wreg,
  input  logic       ex_load,
  input  logic       ex_cp0ren,
  input  logic       ex_mult,
  input  logic       ex_div,
  // Stall / flush sources
  input  logic       inst_stall,
  input  logic       data_stall,
  input  logic       exc_flush,
  // Pipeline controls
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_refresh,
  output logic       idex_stall,
  output logic       idex_refresh,
  output logic       exmem_stall,
  output logic       exmem_refresh,
  output logic       memwb_refresh,
  // Multi-cycle unit status
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Counter preload values: the counter counts LAT-1 down to 0, giving
  // exactly LAT cycles in BUSY.
  localparam logic [5:0] c_div_cnt = 6'(DIV_LAT - 1);
  localparam logic [5:0] c_mul_cnt = 6'(MUL_LAT - 1);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic       w_md_op;
  logic [5:0] w_lat_cnt;
  logic       w_md_start;
  logic       w_md_stall;
  logic       w_lu_hazard;

`ifdef MD_MULT_MC_EN
  // Divide takes precedence if both flags are ever seen together.
  assign w_md_op   = ex_div | ex_mult;
  assign w_lat_cnt = ex_div ? c_div_cnt : c_mul_cnt;
`else
  // Multiply completes in EX in one cycle; nothing to sequence.
  logic w_unused_cfg;
  assign w_md_op      = ex_div;
  assign w_lat_cnt    = c_div_cnt;
  assign w_unused_cfg = ex_mult ^ (|c_mul_cnt);
`endif

  // Load-use: EX produces its result too late to forward into the ID reader.
  assign w_lu_hazard = (ex_load | ex_cp0ren) & ex_regwen & (ex_wreg != 5'd0) &
                       ((id_rs_ren & (id_rs == ex_wreg)) |
                        (id_rt_ren & (id_rt == ex_wreg)));

  // The MD instruction sits in EX until its result is ready (state DONE).
  assign w_md_stall = w_md_op & (state_q != DONE);

  // Sequencer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next-state: launch, count down, hold result until MEM drains.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_md_start = 1'b0;
    if (exc_flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_md_op) begin
            state_d    = BUSY;
            cnt_d      = w_lat_cnt;
            w_md_start = 1'b1;
          end
        end
        BUSY: begin
          // Keeps counting even while MEM is stalled.
          if (cnt_q == 6'd0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        DONE: begin
          if (!data_stall) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // Prioritised stall/refresh decode; reset bubbles every stage.
  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_refresh  = 1'b0;
    idex_stall    = 1'b0;
    idex_refresh  = 1'b0;
    exmem_stall   = 1'b0;
    exmem_refresh = 1'b0;
    memwb_refresh = 1'b0;
    md_start      = 1'b0;
    md_busy       = 1'b0;
    md_done       = 1'b0;
    if (reset) begin
      ifid_refresh  = 1'b1;
      idex_refresh  = 1'b1;
      exmem_refresh = 1'b1;
      memwb_refresh = 1'b1;
    end else begin
      md_start = w_md_start;
      md_busy  = (state_q != IDLE);
      md_done  = (state_q == DONE);
      if (exc_flush) begin
        ifid_refresh  = 1'b1;
        idex_refresh  = 1'b1;
        exmem_refresh = 1'b1;
      end else if (data_stall) begin
        pc_stall      = 1'b1;
        ifid_stall    = 1'b1;
        idex_stall    = 1'b1;
        exmem_stall   = 1'b1;
        memwb_refresh = 1'b1;
      end else if (w_md_stall) begin
        pc_stall      = 1'b1;
        ifid_stall    = 1'b1;
        idex_stall    = 1'b1;
        exmem_refresh = 1'b1;
      end else if (w_lu_hazard) begin
        pc_stall      = 1'b1;
        ifid_stall    = 1'b1;
        idex_refresh  = 1'b1;
      end else if (inst_stall) begin
        pc_stall      = 1'b1;
        ifid_refresh  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
